port_flr_responder: RTL and testbench

Services per-port VF Function Level Reset requests coming from the PCIe sideband and returns FLR completions to the host. Each request is a VF number. The block holds the matching PR-slot port in reset, waits for that port to quiesce, then signals completion. It sits in the port gasket between the PCIe sideband (the `flr_rcvd_vf` / `flr_rcvd_vf_num` direction) and the per-port reset tree, and drives the completion direction (`flr_completed_vf`).

---
 rtl/port_flr_responder.sv | 187 ++++++++++++++++++
 tb/tb_port_flr_responder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/port_flr_responder.sv
// VF Function Level Reset responder: queues per-port FLR requests, holds the
// selected port in reset until it quiesces (or times out), then reports completion.
module port_flr_responder #(
    parameter int PG_NUM_PORTS    = 1,
    parameter int VF_NUM_WIDTH    = 11,
    parameter int RST_HOLD_CYCLES = 16,
    parameter int QUIESCE_TIMEOUT = 4096
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_flr_rcvd_vf,
    input  logic [VF_NUM_WIDTH-1:0] i_flr_rcvd_vf_num,
    input  logic [PG_NUM_PORTS-1:0] i_port_quiesced,
    input  logic                    i_err_clr,
    output logic [PG_NUM_PORTS-1:0] o_port_flr_rst_n,
    output logic                    o_flr_completed_vf,
    output logic [VF_NUM_WIDTH-1:0] o_flr_completed_vf_num,
    output logic                    o_flr_busy,
    output logic                    o_flr_timeout_err,
    output logic                    o_flr_num_err
);

    localparam int IDX_W  = (PG_NUM_PORTS > 1) ? $clog2(PG_NUM_PORTS) : 1;
    localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
    localparam int TO_W   = (QUIESCE_TIMEOUT > 0) ? $clog2(QUIESCE_TIMEOUT + 1) : 1;
    localparam int VFW1   = VF_NUM_WIDTH + 1;
    localparam bit TO_EN  = (QUIESCE_TIMEOUT > 0);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(RST_HOLD_CYCLES);
    localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(QUIESCE_TIMEOUT);
    localparam logic [VFW1-1:0]   MAX_VF    = VFW1'(PG_NUM_PORTS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_QUIESCE,
        ST_COMPLETE
    } state_t;

    state_t                  state_reg, state_next;
    logic [PG_NUM_PORTS-1:0] pending_reg, pending_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic [HOLD_W-1:0]       hold_cnt_reg, hold_cnt_next;
    logic [TO_W-1:0]         to_cnt_reg, to_cnt_next;

    logic [PG_NUM_PORTS-1:0] port_rst_n_reg, port_rst_n_next;
    logic                    done_reg, done_next;
    logic [VF_NUM_WIDTH-1:0] done_num_reg, done_num_next;
    logic                    busy_reg, busy_next;
    logic                    to_err_reg, to_err_next;
    logic                    num_err_reg, num_err_next;

    logic                    num_valid;
    logic                    req_valid;
    logic                    req_bad;
    logic                    in_service;
    logic                    to_fire;
    logic                    quiesced_sel;
    logic [IDX_W-1:0]        sel_idx;
    logic [PG_NUM_PORTS-1:0] sel_mask;
    logic [PG_NUM_PORTS-1:0] cur_mask;
    logic [PG_NUM_PORTS-1:0] req_set;
    logic [PG_NUM_PORTS-1:0] pend_clr;
    logic                    svc_next;

    assign num_valid  = (i_flr_rcvd_vf_num != '0) && ({1'b0, i_flr_rcvd_vf_num} <= MAX_VF);
    assign req_valid  = i_flr_rcvd_vf && num_valid;
    assign req_bad    = i_flr_rcvd_vf && !num_valid;
    assign in_service = (state_reg == ST_ASSERT) || (state_reg == ST_QUIESCE);
    assign svc_next   = (state_next == ST_ASSERT) || (state_next == ST_QUIESCE);

    // Per-port decode: request set (merged away if that port is mid-service),
    // selection/current masks and the registered reset value for each port.
    genvar gi;
    generate
        for (gi = 0; gi < PG_NUM_PORTS; gi++) begin : g_port
            assign req_set[gi]  = req_valid
                                  && (i_flr_rcvd_vf_num == VF_NUM_WIDTH'(gi + 1))
                                  && !(in_service && (idx_reg == IDX_W'(gi)));
            assign sel_mask[gi] = (sel_idx == IDX_W'(gi));
            assign cur_mask[gi] = (idx_reg == IDX_W'(gi));
            assign port_rst_n_next[gi] = !(svc_next && (idx_next == IDX_W'(gi)));
        end
    endgenerate

    assign quiesced_sel = |(i_port_quiesced & cur_mask);

    // Lowest pending index wins.
    always_comb begin
        sel_idx = '0;
        for (int i = PG_NUM_PORTS - 1; i >= 0; i--) begin
            if (pending_reg[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        hold_cnt_next = hold_cnt_reg;
        to_cnt_next   = to_cnt_reg;
        pend_clr      = '0;
        to_fire       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (|pending_reg) begin
                    state_next    = ST_ASSERT;
                    idx_next      = sel_idx;
                    pend_clr      = sel_mask;
                    hold_cnt_next = '0;
                end
            end
            ST_ASSERT: begin
                if (hold_cnt_reg >= HOLD_LAST) begin
                    state_next  = ST_QUIESCE;
                    to_cnt_next = '0;
                end else if (hold_cnt_reg < HOLD_MAX) begin
                    hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
                end
            end
            ST_QUIESCE: begin
                // A port that quiesces on the last allowed cycle is not a timeout.
                if (quiesced_sel) begin
                    state_next = ST_COMPLETE;
                end else if (TO_EN && (to_cnt_reg >= TO_MAX)) begin
                    state_next = ST_COMPLETE;
                    to_fire    = 1'b1;
                end else if (to_cnt_reg < TO_MAX) begin
                    to_cnt_next = to_cnt_reg + TO_W'(1);
                end
            end
            ST_COMPLETE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        pending_next  = (pending_reg & ~pend_clr) | req_set;
        busy_next     = (state_next != ST_IDLE) || (|pending_next);
        done_next     = (state_next == ST_COMPLETE);
        done_num_next = done_next ? (VF_NUM_WIDTH'(idx_next) + VF_NUM_WIDTH'(1)) : '0;
        to_err_next   = to_fire || (to_err_reg && !i_err_clr);
        num_err_next  = req_bad || (num_err_reg && !i_err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            pending_reg    <= '0;
            idx_reg        <= '0;
            hold_cnt_reg   <= '0;
            to_cnt_reg     <= '0;
            port_rst_n_reg <= '1;
            done_reg       <= 1'b0;
            done_num_reg   <= '0;
            busy_reg       <= 1'b0;
            to_err_reg     <= 1'b0;
            num_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pending_reg    <= pending_next;
            idx_reg        <= idx_next;
            hold_cnt_reg   <= hold_cnt_next;
            to_cnt_reg     <= to_cnt_next;
            port_rst_n_reg <= port_rst_n_next;
            done_reg       <= done_next;
            done_num_reg   <= done_num_next;
            busy_reg       <= busy_next;
            to_err_reg     <= to_err_next;
            num_err_reg    <= num_err_next;
        end
    end

    assign o_port_flr_rst_n       = port_rst_n_reg;
    assign o_flr_completed_vf     = done_reg;
    assign o_flr_completed_vf_num = done_num_reg;
    assign o_flr_busy             = busy_reg;
    assign o_flr_timeout_err      = to_err_reg;
    assign o_flr_num_err          = num_err_reg;

endmodule

// File: tb/tb_port_flr_responder.sv
// Bench for port_flr_responder: 4 ports, hold 16, quiesce timeout 8.
module tb_port_flr_responder;

    localparam int NP = 4;
    localparam int VW = 11;
    localparam int H  = 16;
    localparam int QT = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_flr_rcvd_vf = 1'b0;
    logic [VW-1:0] i_flr_rcvd_vf_num = '0;
    logic [NP-1:0] i_port_quiesced = '0;
    logic          i_err_clr = 1'b0;
    logic [NP-1:0] o_port_flr_rst_n;
    logic          o_flr_completed_vf;
    logic [VW-1:0] o_flr_completed_vf_num;
    logic          o_flr_busy;
    logic          o_flr_timeout_err;
    logic          o_flr_num_err;

    port_flr_responder #(
        .PG_NUM_PORTS   (NP),
        .VF_NUM_WIDTH   (VW),
        .RST_HOLD_CYCLES(H),
        .QUIESCE_TIMEOUT(QT)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .i_flr_rcvd_vf         (i_flr_rcvd_vf),
        .i_flr_rcvd_vf_num     (i_flr_rcvd_vf_num),
        .i_port_quiesced       (i_port_quiesced),
        .i_err_clr             (i_err_clr),
        .o_port_flr_rst_n      (o_port_flr_rst_n),
        .o_flr_completed_vf    (o_flr_completed_vf),
        .o_flr_completed_vf_num(o_flr_completed_vf_num),
        .o_flr_busy            (o_flr_busy),
        .o_flr_timeout_err     (o_flr_timeout_err),
        .o_flr_num_err         (o_flr_num_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records every completion pulse and the worst-case count of ports in reset.
    int obs_num [0:63];
    int obs_cyc [0:63];
    int obs_wr  = 0;
    int max_low = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if ($countones(~o_port_flr_rst_n) > max_low)
                max_low <= $countones(~o_port_flr_rst_n);
            if (o_flr_completed_vf && obs_wr < 64) begin
                obs_num[obs_wr] <= int'(o_flr_completed_vf_num);
                obs_cyc[obs_wr] <= cyc;
                obs_wr          <= obs_wr + 1;
            end
        end
    end

    typedef struct {
        int num;
        int cyc;
    } exp_t;
    exp_t sb_q[$];
    int   obs_rd = 0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int num, input int at);
        exp_t e;
        e.num = num;
        e.cyc = at;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (obs_rd < obs_wr) begin
            $display("completion vf=%0d cycle=%0d", obs_num[obs_rd], obs_cyc[obs_rd]);
            if (sb_q.size() == 0) begin
                chk("unexpected_completion", obs_num[obs_rd], 0);
            end else begin
                e = sb_q.pop_front();
                chk("completion_num", obs_num[obs_rd], e.num);
                chk("completion_cycle", obs_cyc[obs_rd], e.cyc);
            end
            obs_rd++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic send(input int num);
        i_flr_rcvd_vf     = 1'b1;
        i_flr_rcvd_vf_num = VW'(num);
        tick();
        i_flr_rcvd_vf     = 1'b0;
        i_flr_rcvd_vf_num = '0;
    endtask

    typedef struct {
        int num;
        bit q_always;
        int qdelay;       // cycles after QUIESCE entry that quiesce rises; -1 = never
        bit exp_num_err;
        bit exp_done;
        int lat;
        bit exp_to_err;
    } vec_t;

    vec_t vecs[7];
    int   r;
    int   base;

    initial begin
        vecs[0] = '{num: 2, q_always: 1, qdelay: -1, exp_num_err: 0, exp_done: 1, lat: H + 3,  exp_to_err: 0};
        vecs[1] = '{num: 1, q_always: 0, qdelay: 5,  exp_num_err: 0, exp_done: 1, lat: H + 8,  exp_to_err: 0};
        vecs[2] = '{num: 4, q_always: 0, qdelay: QT, exp_num_err: 0, exp_done: 1, lat: H + 3 + QT, exp_to_err: 0};
        vecs[3] = '{num: 3, q_always: 0, qdelay: -1, exp_num_err: 0, exp_done: 1, lat: H + 3 + QT, exp_to_err: 1};
        vecs[4] = '{num: 0, q_always: 1, qdelay: -1, exp_num_err: 1, exp_done: 0, lat: 0,      exp_to_err: 0};
        vecs[5] = '{num: NP + 1, q_always: 1, qdelay: -1, exp_num_err: 1, exp_done: 0, lat: 0, exp_to_err: 0};
        vecs[6] = '{num: 4, q_always: 0, qdelay: 0,  exp_num_err: 0, exp_done: 1, lat: H + 3,  exp_to_err: 0};

        // Reset values
        tick();
        chk("rst_port_rst_n", int'(o_port_flr_rst_n), 'hF);
        chk("rst_done", int'(o_flr_completed_vf), 0);
        chk("rst_done_num", int'(o_flr_completed_vf_num), 0);
        chk("rst_busy", int'(o_flr_busy), 0);
        chk("rst_to_err", int'(o_flr_timeout_err), 0);
        chk("rst_num_err", int'(o_flr_num_err), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single request, cycle by cycle
        i_port_quiesced = '1;
        r = cyc;
        push_exp(2, r + H + 3);
        send(2);
        chk("single_busy_r1", int'(o_flr_busy), 1);
        chk("single_rst_r1", int'(o_port_flr_rst_n), 'hF);
        tick();
        chk("single_rst_r2", int'(o_port_flr_rst_n), 'hD);
        while (cyc < r + H + 2) tick();
        chk("single_rst_last", int'(o_port_flr_rst_n), 'hD);
        tick();
        chk("single_rst_release", int'(o_port_flr_rst_n), 'hF);
        chk("single_done", int'(o_flr_completed_vf), 1);
        tick();
        chk("single_busy_end", int'(o_flr_busy), 0);
        chk("single_done_end", int'(o_flr_completed_vf), 0);
        chk("single_sb_empty", sb_q.size(), 0);

        // Table-driven requests
        foreach (vecs[i]) begin
            i_port_quiesced = vecs[i].q_always ? '1 : '0;
            r = cyc;
            if (vecs[i].exp_done) push_exp(vecs[i].num, r + vecs[i].lat);
            send(vecs[i].num);
            chk("vec_num_err_r1", int'(o_flr_num_err), int'(vecs[i].exp_num_err));
            chk("vec_busy_r1", int'(o_flr_busy), int'(vecs[i].exp_done));
            for (int k = 0; k < 39; k++) begin
                tick();
                if (!vecs[i].q_always && vecs[i].qdelay >= 0 && cyc == r + H + 2 + vecs[i].qdelay)
                    i_port_quiesced = '1;
            end
            chk("vec_sb_empty", sb_q.size(), 0);
            chk("vec_busy_end", int'(o_flr_busy), 0);
            chk("vec_to_err", int'(o_flr_timeout_err), int'(vecs[i].exp_to_err));
            i_err_clr = 1'b1;
            tick();
            i_err_clr = 1'b0;
            chk("vec_to_err_clr", int'(o_flr_timeout_err), 0);
            chk("vec_num_err_clr", int'(o_flr_num_err), 0);
        end

        // Simultaneous pending while port 3 is in service
        i_port_quiesced = '1;
        r = cyc;
        push_exp(4, r + H + 3);
        push_exp(1, r + 2 * H + 6);
        push_exp(3, r + 3 * H + 9);
        send(4);
        tick();
        tick();
        send(3);
        send(1);
        while (cyc < r + 3 * H + 17) begin
            tick();
            if (cyc == r + H + 5) chk("prio_port0_first", int'(o_port_flr_rst_n), 'hE);
            if (cyc == r + 2 * H + 8) chk("prio_port2_second", int'(o_port_flr_rst_n), 'hB);
        end
        chk("prio_sb_empty", sb_q.size(), 0);

        // Merge: repeat request while port 1 is in QUIESCE
        i_port_quiesced = '0;
        r = cyc;
        push_exp(2, r + H + 7);
        send(2);
        while (cyc < r + 45) begin
            tick();
            i_flr_rcvd_vf = (cyc == r + H + 4);
            i_flr_rcvd_vf_num = 11'd2;
            if (cyc == r + H + 6) i_port_quiesced = '1;
        end
        i_flr_rcvd_vf = 1'b0;
        chk("merge_sb_empty", sb_q.size(), 0);
        chk("merge_busy_end", int'(o_flr_busy), 0);

        // Repeat request during COMPLETE triggers a second service
        i_port_quiesced = '1;
        r = cyc;
        push_exp(2, r + H + 3);
        push_exp(2, r + 2 * H + 6);
        send(2);
        while (cyc < r + 2 * H + 14) begin
            tick();
            i_flr_rcvd_vf = 1'b0;
            if (cyc == r + H + 3) begin
                chk("repeat_in_complete", int'(o_flr_completed_vf), 1);
                i_flr_rcvd_vf = 1'b1;
                i_flr_rcvd_vf_num = 11'd2;
            end
        end
        i_flr_rcvd_vf = 1'b0;
        chk("repeat_sb_empty", sb_q.size(), 0);
        chk("repeat_busy_end", int'(o_flr_busy), 0);

        // Error set and clear in the same cycle: set wins
        i_flr_rcvd_vf = 1'b1;
        i_flr_rcvd_vf_num = '0;
        i_err_clr = 1'b1;
        tick();
        i_flr_rcvd_vf = 1'b0;
        i_err_clr = 1'b0;
        chk("err_set_wins", int'(o_flr_num_err), 1);
        tick();
        chk("err_sticky", int'(o_flr_num_err), 1);
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        chk("err_cleared", int'(o_flr_num_err), 0);

        // Reset during ASSERT aborts the service
        i_port_quiesced = '1;
        base = obs_wr;
        send(1);
        for (int k = 0; k < 4; k++) tick();
        chk("abort_in_assert", int'(o_port_flr_rst_n), 'hE);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_rst_release", int'(o_port_flr_rst_n), 'hF);
        chk("abort_busy", int'(o_flr_busy), 0);
        chk("abort_done", int'(o_flr_completed_vf), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("abort_pending_cleared", int'(o_flr_busy), 0);
        for (int k = 0; k < 40; k++) tick();
        chk("abort_no_completion", obs_wr - base, 0);
        chk("abort_busy_end", int'(o_flr_busy), 0);

        chk("max_ports_low", max_low, 1);
        chk("final_sb_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
